// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, samples the instruction word and fills the IF/ID register.
// Latency: instWord sampled in cycle N appears on id_* after the edge ending cycle N.
// Backpressure: stall holds the PC and IF/ID contents; a redirect overrides stall and squashes the fetch.
module fetch_stage #(
    parameter int              DBITS         = 32,
    parameter logic [DBITS-1:0] INST_SIZE     = 'd4,
    parameter logic [DBITS-1:0] START_PC      = 'h40,
    parameter logic [DBITS-1:0] NOP_WORD      = '0,
    parameter bit              HALT_ON_FAULT = 1'b1
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    output logic [DBITS-1:0] pcOut,
    input  logic [DBITS-1:0] instWord,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [DBITS-1:0] redirect_pc,
    output logic [DBITS-1:0] id_inst,
    output logic [DBITS-1:0] id_pc,
    output logic [DBITS-1:0] id_pc_plus4,
    output logic             id_valid,
    output logic             align_fault,
    output logic             halted,
    output logic [DBITS-1:0] fetch_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [DBITS-1:0] pc, pc_nxt;
    logic [DBITS-1:0] inst_nxt, ipc_nxt, ip4_nxt, cnt_nxt;
    logic             valid_nxt, fault_nxt;

    assign pcOut  = pc;
    assign halted = (state == HALT);

    // State register; reset always restarts through BOOT.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // PC, IF/ID pipeline register, fault flag and fetch counter.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            pc          <= START_PC;
            id_inst     <= NOP_WORD;
            id_pc       <= '0;
            id_pc_plus4 <= '0;
            id_valid    <= 1'b0;
            align_fault <= 1'b0;
            fetch_count <= '0;
        end else begin
            pc          <= pc_nxt;
            id_inst     <= inst_nxt;
            id_pc       <= ipc_nxt;
            id_pc_plus4 <= ip4_nxt;
            id_valid    <= valid_nxt;
            align_fault <= fault_nxt;
            fetch_count <= cnt_nxt;
        end
    end

    // Next-state and datapath selection: redirect beats stall beats a normal fetch.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        inst_nxt  = id_inst;
        ipc_nxt   = id_pc;
        ip4_nxt   = id_pc_plus4;
        valid_nxt = id_valid;
        fault_nxt = align_fault;
        cnt_nxt   = fetch_count;
        case (state)
            BOOT: begin
                // Redirects and stalls are ignored while booting.
                state_nxt = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    pc_nxt    = {redirect_pc[DBITS-1:2], 2'b00};
                    valid_nxt = 1'b0;
                    inst_nxt  = NOP_WORD;
                    if (redirect_pc[1:0] != 2'b00) begin
                        fault_nxt = 1'b1;
                        if (HALT_ON_FAULT) begin
                            state_nxt = HALT;
                        end
                    end
                end else if (!stall) begin
                    inst_nxt  = instWord;
                    ipc_nxt   = pc;
                    ip4_nxt   = pc + INST_SIZE;
                    valid_nxt = 1'b1;
                    pc_nxt    = pc + INST_SIZE;
                    // Saturate instead of wrapping.
                    cnt_nxt   = (&fetch_count) ? fetch_count : fetch_count + DBITS'(1);
                end
            end
            HALT: begin
                // Frozen until reset; keep the slot a bubble.
                valid_nxt = 1'b0;
                inst_nxt  = NOP_WORD;
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic against a behavioural model.
// Instruction memory is a combinational hash of the address.
// Outputs are sampled 1ns after each rising edge; inputs change on the falling edge.
module tb_fetch_stage;

    logic        clk;
    logic        RESET;
    logic [31:0] pcOut;
    logic [31:0] instWord;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        id_valid;
    logic        align_fault;
    logic        halted;
    logic [31:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: mode 0 = booting, 1 = running, 2 = halted.
    int          m_mode;
    logic [31:0] m_pc, m_inst, m_ipc, m_ip4, m_cnt;
    logic        m_valid, m_fault;

    fetch_stage dut (
        .CLOCK_50       (clk),
        .RESET          (RESET),
        .pcOut          (pcOut),
        .instWord       (instWord),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_valid       (id_valid),
        .align_fault    (align_fault),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    assign instWord = mem(pcOut);

    wire [162:0] dut_vec = {pcOut, id_inst, id_pc, id_pc_plus4, fetch_count,
                            id_valid, align_fault, halted};

    function automatic logic [162:0] exp_vec();
        return {m_pc, m_inst, m_ipc, m_ip4, m_cnt, m_valid, m_fault, (m_mode == 2)};
    endfunction

    // One clock: drive inputs on the falling edge, advance the model at the rising edge.
    task automatic cycle(input bit rst, input bit st, input bit rv, input logic [31:0] rpc);
        @(negedge clk);
        RESET          = rst;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        if (rst) begin
            m_mode = 0; m_pc = 32'h40; m_inst = 32'h0; m_ipc = 32'h0; m_ip4 = 32'h0;
            m_valid = 1'b0; m_fault = 1'b0; m_cnt = 32'h0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (rv) begin
                m_pc    = rpc & 32'hFFFF_FFFC;
                m_valid = 1'b0;
                m_inst  = 32'h0;
                if (rpc % 4 != 0) begin
                    m_fault = 1'b1;
                    m_mode  = 2;
                end
            end else if (!st) begin
                m_inst  = mem(m_pc);
                m_ipc   = m_pc;
                m_ip4   = m_pc + 32'd4;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0123);
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_0088);
        checks++;
        if (pcOut !== 32'h40 || id_valid !== 1'b0 || fetch_count !== 32'h0 ||
            halted !== 1'b0 || align_fault !== 1'b0 || id_inst !== 32'h0) begin
            failures++;
            $display("FAIL reset_values got pc=%h v=%b cnt=%h h=%b f=%b inst=%h want pc=40 v=0 cnt=0 h=0 f=0 inst=0",
                     pcOut, id_valid, fetch_count, halted, align_fault, id_inst);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL reset_model got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_sequential();
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0200);  // BOOT: redirect ignored
        checks++;
        if (pcOut !== 32'h40 || id_valid !== 1'b0) begin
            failures++;
            $display("FAIL boot_hold got pc=%h v=%b want pc=40 v=0", pcOut, id_valid);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (pcOut !== 32'h44 || id_valid !== 1'b1 || id_pc !== 32'h40 ||
            id_pc_plus4 !== 32'h44 || id_inst !== mem(32'h40)) begin
            failures++;
            $display("FAIL first_fetch got pc=%h v=%b ipc=%h ip4=%h inst=%h want pc=44 v=1 ipc=40 ip4=44 inst=%h",
                     pcOut, id_valid, id_pc, id_pc_plus4, id_inst, mem(32'h40));
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (pcOut !== 32'h4C || id_pc !== 32'h48 || fetch_count !== 32'd3) begin
            failures++;
            $display("FAIL sequential got pc=%h ipc=%h cnt=%0d want pc=4c ipc=48 cnt=3",
                     pcOut, id_pc, fetch_count);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 32'h0);
            checks++;
            if (pcOut !== 32'h4C || id_pc !== 32'h48 || id_valid !== 1'b1 ||
                id_inst !== mem(32'h48) || fetch_count !== 32'd3) begin
                failures++;
                $display("FAIL stall_hold[%0d] got pc=%h ipc=%h v=%b cnt=%0d want pc=4c ipc=48 v=1 cnt=3",
                         i, pcOut, id_pc, id_valid, fetch_count);
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (pcOut !== 32'h50 || id_pc !== 32'h4C || fetch_count !== 32'd4) begin
            failures++;
            $display("FAIL stall_resume got pc=%h ipc=%h cnt=%0d want pc=50 ipc=4c cnt=4",
                     pcOut, id_pc, fetch_count);
        end
    endtask

    task automatic test_stall_redirect();
        cycle(1'b0, 1'b1, 1'b1, 32'h60);
        checks++;
        if (pcOut !== 32'h60 || id_valid !== 1'b0 || id_inst !== 32'h0) begin
            failures++;
            $display("FAIL stall_redirect got pc=%h v=%b inst=%h want pc=60 v=0 inst=0",
                     pcOut, id_valid, id_inst);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (id_pc !== 32'h60 || id_valid !== 1'b1 || pcOut !== 32'h64) begin
            failures++;
            $display("FAIL redirect_target got ipc=%h v=%b pc=%h want ipc=60 v=1 pc=64",
                     id_pc, id_valid, pcOut);
        end
        cycle(1'b0, 1'b0, 1'b1, 32'h64);  // redirect to the current pc
        checks++;
        if (pcOut !== 32'h64 || id_valid !== 1'b0 || fetch_count !== 32'd5) begin
            failures++;
            $display("FAIL redirect_same_pc got pc=%h v=%b cnt=%0d want pc=64 v=0 cnt=5",
                     pcOut, id_valid, fetch_count);
        end
    endtask

    task automatic test_misaligned_halt();
        cycle(1'b0, 1'b0, 1'b1, 32'h62);
        checks++;
        if (pcOut !== 32'h60 || align_fault !== 1'b1 || halted !== 1'b1 || id_valid !== 1'b0) begin
            failures++;
            $display("FAIL misaligned got pc=%h f=%b h=%b v=%b want pc=60 f=1 h=1 v=0",
                     pcOut, align_fault, halted, id_valid);
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'($urandom), 1'($urandom), $urandom);
            checks++;
            if (pcOut !== 32'h60 || id_valid !== 1'b0 || halted !== 1'b1 || id_inst !== 32'h0) begin
                failures++;
                $display("FAIL halt_hold[%0d] got pc=%h v=%b h=%b inst=%h want pc=60 v=0 h=1 inst=0",
                         i, pcOut, id_valid, halted, id_inst);
            end
        end
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (pcOut !== 32'h40 || align_fault !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_reset got pc=%h f=%b h=%b want pc=40 f=0 h=0",
                     pcOut, align_fault, halted);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b0, 1'b0, 1'b0, 32'h0);  // BOOT
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (pcOut !== 32'h0 || id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'h0 ||
            id_valid !== 1'b1 || align_fault !== 1'b0) begin
            failures++;
            $display("FAIL pc_wrap got pc=%h ipc=%h ip4=%h v=%b f=%b want pc=0 ipc=fffffffc ip4=0 v=1 f=0",
                     pcOut, id_pc, id_pc_plus4, id_valid, align_fault);
        end
    endtask

    task automatic test_midstream_reset();
        cycle(1'b0, 1'b0, 1'b1, 32'h54);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (pcOut !== 32'h58 || id_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset got pc=%h v=%b want pc=58 v=1", pcOut, id_valid);
        end
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (pcOut !== 32'h40 || id_valid !== 1'b0 || fetch_count !== 32'h0 || id_pc !== 32'h0 ||
            id_pc_plus4 !== 32'h0 || id_inst !== 32'h0 || halted !== 1'b0 || align_fault !== 1'b0) begin
            failures++;
            $display("FAIL midstream_reset got %h want pc=40 and all id_* cleared", dut_vec);
        end
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        for (int i = 0; i < 600; i++) begin
            rpc = $urandom & 32'h0000_0FFC;
            if ($urandom_range(0, 39) == 0) rpc = rpc | 32'($urandom_range(1, 3));
            cycle($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, rpc);
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL random[%0d] got %h want %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        RESET          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        m_mode = 0; m_pc = 32'h40; m_inst = 32'h0; m_ipc = 32'h0; m_ip4 = 32'h0;
        m_valid = 1'b0; m_fault = 1'b0; m_cnt = 32'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_stall_redirect();
        test_misaligned_halt();
        test_wrap();
        test_midstream_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
